reset_sequencer: RTL

Power-on and push-button reset controller for the Raven68k CPLD. It sequences start-up of the `clock` divider module: enables the clock, latches the divide ratio, holds the 68000 in RESET/HALT for a fixed period, then releases it. It also debounces the front-panel reset button and derives the peripheral reset from the CPU's own RESET-instruction output.

---
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Board-side signal bundle of the Raven68k reset sequencer.
// The master modport is the sequencer; the slave modport is the board/CPU side.
interface reset_sequencer_if;
    logic       btn_n;
    logic       cpu_rst_io_n;
    logic [1:0] cfg_div;
    logic       clk_run;
    logic [1:0] clk_div;
    logic       cpu_reset_n;
    logic       cpu_halt_n;
    logic       periph_reset_n;

    modport master (
        input  btn_n, cpu_rst_io_n, cfg_div,
        output clk_run, clk_div, cpu_reset_n, cpu_halt_n, periph_reset_n
    );

    modport slave (
        output btn_n, cpu_rst_io_n, cfg_div,
        input  clk_run, clk_div, cpu_reset_n, cpu_halt_n, periph_reset_n
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / push-button reset controller for the Raven68k: sequences the clock
// divider start-up, holds the 68000 in RESET/HALT, and debounces the front-panel button.
module reset_sequencer #(
    parameter int CLK_WAIT_CYC = 16,
    parameter int POR_CYC      = 1000000,
    parameter int WARM_CYC     = 2000,
    parameter int DEB_CYC      = 8,
    parameter int CNT_W        = 20
) (
    input  logic              clk_in,
    input  logic              reset,
    reset_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLKWAIT = 3'd1,
        HOLD    = 3'd2,
        RUN     = 3'd3,
        BTN     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLK_WAIT_LD = CNT_W'(CLK_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] POR_LD      = CNT_W'(POR_CYC - 1);
    localparam logic [CNT_W-1:0] WARM_LD     = CNT_W'(WARM_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       btnSync_q;
    logic [1:0]       rstIoSync_q;
    logic             debLevel_q, debLevel_d;
    logic [CNT_W-1:0] debCnt_q, debCnt_d;
    logic [1:0]       clkDiv_q, clkDiv_d;
    logic             clkRun_q;
    logic             cpuResetN_q;
    logic             cpuHaltN_q;
    logic             periphResetN_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            btnSync_q   <= 2'b11;
            rstIoSync_q <= 2'b11;
        end else begin
            btnSync_q   <= {btnSync_q[0], bus.btn_n};
            rstIoSync_q <= {rstIoSync_q[0], bus.cpu_rst_io_n};
        end
    end

    // The level flips on the edge that counts the DEB_CYC-th consecutive differing sample.
    always_comb begin
        debLevel_d = debLevel_q;
        debCnt_d   = CNT_ZERO;
        if (btnSync_q[1] != debLevel_q) begin
            if (debCnt_q == DEB_LAST) begin
                debLevel_d = ~debLevel_q;
            end else begin
                debCnt_d = debCnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            debLevel_q <= 1'b1;
            debCnt_q   <= CNT_ZERO;
        end else begin
            debLevel_q <= debLevel_d;
            debCnt_q   <= debCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clkDiv_d = clkDiv_q;
        case (state_q)
            IDLE: begin
                state_d  = CLKWAIT;
                cnt_d    = CLK_WAIT_LD;
                clkDiv_d = bus.cfg_div;
            end
            CLKWAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = HOLD;
                    cnt_d   = POR_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                if (!debLevel_q) begin
                    state_d  = BTN;
                    clkDiv_d = bus.cfg_div;
                end
            end
            BTN: begin
                if (debLevel_q) begin
                    state_d = HOLD;
                    cnt_d   = WARM_LD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= CNT_ZERO;
            clkDiv_q       <= 2'b00;
            clkRun_q       <= 1'b0;
            cpuResetN_q    <= 1'b0;
            cpuHaltN_q     <= 1'b0;
            periphResetN_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            clkDiv_q       <= clkDiv_d;
            clkRun_q       <= (state_d != IDLE);
            cpuResetN_q    <= (state_d == RUN);
            cpuHaltN_q     <= (state_d == RUN);
            periphResetN_q <= (state_d == RUN) && rstIoSync_q[1];
        end
    end

    assign bus.clk_run        = clkRun_q;
    assign bus.clk_div        = clkDiv_q;
    assign bus.cpu_reset_n    = cpuResetN_q;
    assign bus.cpu_halt_n     = cpuHaltN_q;
    assign bus.periph_reset_n = periphResetN_q;

endmodule
